// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle for the RAW hazard detector.
// Decode side (master) presents the current instruction's source operands
// and destination, plus the flush strobe. Scoreboard side (slave) returns
// the stall request, per-port hit flags, the stall counter and the
// watchdog flag.
//   rd_en/rd_addr        : NREAD source operands, port i at [i*ADDR_W +: ADDR_W]
//   wr_en/wr_addr        : destination of the decode-stage instruction
//   wr_is_load           : destination comes from a load
//   flush                : kill every tracked entry
//   bbl/hit_vec          : combinational stall request and per-port hits
//   stall_cnt/stuck      : saturating stall count, sticky watchdog
// Handshake: bbl acts as an inverted ready for the decode stage. While
// bbl=1 the decode instruction is held (PC/IF-ID frozen, bubble into ID-EX)
// and is not recorded; it is recorded on the first cycle it sees bbl=0.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 16
);
  logic [NREAD-1:0]        rd_en;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    wr_is_load;
  logic                    flush;
  logic                    bbl;
  logic [NREAD-1:0]        hit_vec;
  logic [CNT_W-1:0]        stall_cnt;
  logic                    stuck;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_is_load, flush,
    input  bbl, hit_vec, stall_cnt, stuck
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_is_load, flush,
    output bbl, hit_vec, stall_cnt, stuck
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard detector for the in-order pipeline.
// Keeps the destinations of the last DEPTH issued instructions in a shift
// scoreboard (entry 0 newest) and compares the decode-stage source operands
// against it. With FWD_EN=1 only loads younger than LOAD_LAT entries stall.
// Also keeps a saturating stall-cycle counter and a watchdog that flags a
// stall lasting longer than any legal hazard can.
// Ports:
//   clk  : pipeline clock
//   rst  : asynchronous, active-high reset
//   bus  : hazard_scoreboard_if.slave (operands, destination, flush, outputs)
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int DEPTH    = 2,
  parameter bit FWD_EN   = 1'b0,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  // Run counter only needs to reach DEPTH+1, where it saturates.
  localparam int RUN_W = $clog2(DEPTH + 2);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH*ADDR_W-1:0] addr_q,  addr_d;
  logic [DEPTH-1:0]        load_q,  load_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [RUN_W-1:0]        run_q,   run_d;
  logic                    stuck_q, stuck_d;

  logic [NREAD-1:0]        hit;
  logic                    bbl;

  // Hazard compare. Only recorded (older) entries are examined, so an
  // instruction reading its own destination never stalls itself.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (valid_q[k] &&
            addr_q[k*ADDR_W +: ADDR_W] == bus.rd_addr[i*ADDR_W +: ADDR_W] &&
            (!FWD_EN || (load_q[k] && k < LOAD_LAT))) begin
          hit[i] = 1'b1;
        end
      end
      if (!bus.rd_en[i] || bus.rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
        hit[i] = 1'b0;
      end
    end
    if (rst || bus.flush) begin
      hit = '0;
    end
  end

  assign bbl = |hit;

  // Scoreboard shift: a stalled instruction is replaced by a bubble.
  always_comb begin
    valid_d = '0;
    addr_d  = '0;
    load_d  = '0;
    if (!bus.flush) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k]                = valid_q[k-1];
        addr_d[k*ADDR_W +: ADDR_W] = addr_q[(k-1)*ADDR_W +: ADDR_W];
        load_d[k]                 = load_q[k-1];
      end
      if (!bbl) begin
        valid_d[0]         = bus.wr_en && (bus.wr_addr != '0);
        addr_d[ADDR_W-1:0] = bus.wr_addr;
        load_d[0]          = bus.wr_is_load;
      end
    end
  end

  // Stall counter and watchdog. A legal hazard drains within DEPTH bubble
  // cycles, so DEPTH+1 consecutive stalls means the pipeline is wedged.
  always_comb begin
    cnt_d   = cnt_q;
    run_d   = '0;
    stuck_d = stuck_q;
    if (bbl && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (!bus.flush && bbl) begin
      run_d = (run_q == RUN_W'(DEPTH + 1)) ? run_q : run_q + 1'b1;
      if (run_q == RUN_W'(DEPTH)) begin
        stuck_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      addr_q  <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      stuck_q <= stuck_d;
    end
  end

  assign bus.bbl       = bbl;
  assign bus.hit_vec   = hit;
  assign bus.stall_cnt = cnt_q;
  assign bus.stuck     = stuck_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (default, forwarding-aware,
// 4-bit counter). Directed cycles push expected outputs into exp_q; a
// negedge monitor pops and compares against the selected instance.
module tb_hazard_scoreboard;

  localparam int REC_W = 22; // {sel[1:0], bbl, hit[1:0], cnt[15:0], stuck}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   mon_cyc  = 0;

  logic [REC_W-1:0] exp_q[$];

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(5), .NREAD(2), .CNT_W(16)) if_a ();
  hazard_scoreboard_if #(.ADDR_W(5), .NREAD(2), .CNT_W(16)) if_f ();
  hazard_scoreboard_if #(.ADDR_W(5), .NREAD(2), .CNT_W(4))  if_c ();

  hazard_scoreboard #(.ADDR_W(5), .NREAD(2), .DEPTH(2), .FWD_EN(1'b0),
                      .LOAD_LAT(1), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  hazard_scoreboard #(.ADDR_W(5), .NREAD(2), .DEPTH(2), .FWD_EN(1'b1),
                      .LOAD_LAT(1), .CNT_W(16))
    dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));
  hazard_scoreboard #(.ADDR_W(5), .NREAD(2), .DEPTH(2), .FWD_EN(1'b0),
                      .LOAD_LAT(1), .CNT_W(4))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // ---------------- compare helper ----------------
  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    if_a.rd_en = '0; if_a.rd_addr = '0; if_a.wr_en = 1'b0; if_a.wr_addr = '0;
    if_a.wr_is_load = 1'b0; if_a.flush = 1'b0;
    if_f.rd_en = '0; if_f.rd_addr = '0; if_f.wr_en = 1'b0; if_f.wr_addr = '0;
    if_f.wr_is_load = 1'b0; if_f.flush = 1'b0;
    if_c.rd_en = '0; if_c.rd_addr = '0; if_c.wr_en = 1'b0; if_c.wr_addr = '0;
    if_c.wr_is_load = 1'b0; if_c.flush = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One decode cycle on instance sel plus the outputs expected during it.
  task automatic cyc(input int sel, input logic [1:0] re,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic we, input logic [4:0] wa,
                     input logic ld, input logic fl,
                     input logic eb, input logic [1:0] eh,
                     input logic [15:0] ec, input logic es);
    logic [1:0] s2;
    @(posedge clk); #1;
    idle_all();
    case (sel)
      0: begin
        if_a.rd_en = re; if_a.rd_addr = {a1, a0}; if_a.wr_en = we;
        if_a.wr_addr = wa; if_a.wr_is_load = ld; if_a.flush = fl;
      end
      1: begin
        if_f.rd_en = re; if_f.rd_addr = {a1, a0}; if_f.wr_en = we;
        if_f.wr_addr = wa; if_f.wr_is_load = ld; if_f.flush = fl;
      end
      default: begin
        if_c.rd_en = re; if_c.rd_addr = {a1, a0}; if_c.wr_en = we;
        if_c.wr_addr = wa; if_c.wr_is_load = ld; if_c.flush = fl;
      end
    endcase
    s2 = sel[1:0];
    exp_q.push_back({s2, eb, eh, ec, es});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [REC_W-1:0] rec;
  logic [1:0]  m_sel;
  logic        a_bbl, a_stuck;
  logic [1:0]  a_hit;
  logic [15:0] a_cnt;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec   = exp_q.pop_front();
      m_sel = rec[21:20];
      case (m_sel)
        2'd0: begin
          a_bbl = if_a.bbl; a_hit = if_a.hit_vec;
          a_cnt = if_a.stall_cnt; a_stuck = if_a.stuck;
        end
        2'd1: begin
          a_bbl = if_f.bbl; a_hit = if_f.hit_vec;
          a_cnt = if_f.stall_cnt; a_stuck = if_f.stuck;
        end
        default: begin
          a_bbl = if_c.bbl; a_hit = if_c.hit_vec;
          a_cnt = {12'd0, if_c.stall_cnt}; a_stuck = if_c.stuck;
        end
      endcase
      check($sformatf("bbl[dut%0d]", m_sel), mon_cyc, 32'(a_bbl), 32'(rec[19]));
      check($sformatf("hit_vec[dut%0d]", m_sel), mon_cyc, 32'(a_hit), 32'(rec[18:17]));
      check($sformatf("stall_cnt[dut%0d]", m_sel), mon_cyc, 32'(a_cnt), 32'(rec[16:1]));
      check($sformatf("stuck[dut%0d]", m_sel), mon_cyc, 32'(a_stuck), 32'(rec[0]));
      mon_cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=done", mon_cyc);
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  int stalls;
  logic eb_s;

  initial begin
    idle_all();
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic RAW stall, port-1 hazard, self-dependency, dual-port duplicate
    cyc(0, 2'b00, 0, 0, 1, 3, 0, 0,  0, 2'b00, 0, 0);
    cyc(0, 2'b01, 3, 0, 1, 4, 0, 0,  1, 2'b01, 0, 0);
    cyc(0, 2'b01, 3, 0, 1, 4, 0, 0,  1, 2'b01, 1, 0);
    cyc(0, 2'b01, 3, 0, 1, 4, 0, 0,  0, 2'b00, 2, 0);
    cyc(0, 2'b11, 3, 4, 0, 0, 0, 0,  1, 2'b10, 2, 0);
    cyc(0, 2'b11, 3, 4, 0, 0, 0, 0,  1, 2'b10, 3, 0);
    cyc(0, 2'b11, 3, 4, 0, 0, 0, 0,  0, 2'b00, 4, 0);
    cyc(0, 2'b01, 6, 0, 1, 6, 0, 0,  0, 2'b00, 4, 0);
    cyc(0, 2'b11, 6, 6, 0, 0, 0, 0,  1, 2'b11, 4, 0);
    cyc(0, 2'b11, 6, 6, 0, 0, 0, 0,  1, 2'b11, 5, 0);
    cyc(0, 2'b11, 6, 6, 0, 0, 0, 0,  0, 2'b00, 6, 0);

    // r0 never hazards
    do_reset();
    cyc(0, 2'b00, 0, 0, 1, 0, 0, 0,  0, 2'b00, 0, 0);
    cyc(0, 2'b11, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);
    cyc(0, 2'b11, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);

    // Flush masks the pending hazard, empties entries, records nothing
    do_reset();
    cyc(0, 2'b00, 0, 0, 1, 7, 0, 0,  0, 2'b00, 0, 0);
    cyc(0, 2'b01, 7, 0, 1, 7, 0, 1,  0, 2'b00, 0, 0);
    cyc(0, 2'b01, 7, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);
    cyc(0, 2'b01, 7, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);

    // Forwarding-aware: ALU result no stall, load-use exactly one bubble
    do_reset();
    cyc(1, 2'b00, 0, 0, 1, 5, 0, 0,  0, 2'b00, 0, 0);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);
    cyc(1, 2'b00, 0, 0, 1, 5, 1, 0,  0, 2'b00, 0, 0);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0,  1, 2'b01, 0, 0);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0,  0, 2'b00, 1, 0);
    cyc(1, 2'b01, 5, 0, 0, 0, 0, 0,  0, 2'b00, 1, 0);

    // 4-bit counter saturation over a chain of dependent instructions
    do_reset();
    cyc(2, 2'b00, 0, 0, 1, 1, 0, 0,  0, 2'b00, 0, 0);
    stalls = 0;
    for (int j = 1; j <= 10; j++) begin
      for (int s = 0; s < 3; s++) begin
        eb_s = (s < 2);
        cyc(2, 2'b01, 5'(j), 0, 1, 5'(j + 1), 0, 0,
            eb_s, eb_s ? 2'b01 : 2'b00, 16'((stalls > 15) ? 15 : stalls), 0);
        if (eb_s) stalls++;
      end
    end
    cyc(2, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 15, 0);
    cyc(2, 2'b01, 11, 0, 0, 0, 0, 0,  1, 2'b01, 15, 0);

    // Asynchronous reset in the middle of that stall
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_bbl", mon_cyc, 32'(if_c.bbl), 32'd0);
    check("rst_hit_vec", mon_cyc, 32'(if_c.hit_vec), 32'd0);
    check("rst_stall_cnt", mon_cyc, 32'(if_c.stall_cnt), 32'd0);
    check("rst_stuck", mon_cyc, 32'(if_c.stuck), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();

    // Watchdog: backdoor-pinned entries hold a hazard for 3 cycles
    do_reset();
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);
    force dut_a.valid_q = 2'b11;
    force dut_a.addr_q  = 10'b01001_01001;
    cyc(0, 2'b01, 9, 0, 0, 0, 0, 0,  1, 2'b01, 0, 0);
    cyc(0, 2'b01, 9, 0, 0, 0, 0, 0,  1, 2'b01, 1, 0);
    cyc(0, 2'b01, 9, 0, 0, 0, 0, 0,  1, 2'b01, 2, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 3, 1);
    release dut_a.valid_q;
    release dut_a.addr_q;
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 3, 1);
    cyc(0, 2'b01, 9, 0, 0, 0, 0, 0,  0, 2'b00, 3, 1);
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 3, 1);
    do_reset();
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0);

    // Drain and report
    for (int w = 0; w < 8 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain cyc=%0d actual=%0d required=0", mon_cyc, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
